// File: rtl/apb_cmd_sequencer_pkg.sv
// Shared types for the APB command sequencer: command opcodes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package apb_cmd_sequencer_pkg;

    // Command word layout, MSB first: {op[1:0], addr[AW-1:0], mask[DW-1:0], data[DW-1:0]}
    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,   // re-read until (PRDATA & mask) == (data & mask)
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_ACCESS,
        S_CHECK,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_e;

    function automatic int cmd_width(input int aw, input int dw);
        return OP_W + aw + 2 * dw;
    endfunction

endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// APB bus bundle between the command sequencer (master) and a register slave.
// Latency: n/a (wires only).
// Backpressure: slave stretches the access phase by holding PREADY low.
// Ports: PADDR/PWRITE/PSEL/PENABLE/PWDATA driven by master; PRDATA/PREADY driven by slave.
interface apb_cmd_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_cmd_sequencer_ram.sv
// Command script storage: DEPTH x CW, one synchronous write port, asynchronous read.
// Latency: write visible to reads after the writing edge; read is combinational.
// Backpressure: none; the caller gates writes.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module apb_cmd_sequencer_ram #(
    parameter int DEPTH = 16,
    parameter int CW    = 74,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [CW-1:0] rdata
);
    // Contents are deliberately not reset: a script survives a sequencer reset.
    logic [CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/apb_cmd_sequencer.sv
// APB master that executes a loaded WRITE/READ/POLL/END script against a register slave.
// Latency: start -> PSEL after two edges; 5 cycles per WRITE/READ with zero wait-states.
// Backpressure: PREADY low holds the access phase; POLL retries are spaced by POLL_GAP idle cycles.
// Ports: clk/reset; cmd_we/cmd_waddr/cmd_wdata load slots; start/poll_limit launch a run;
//        busy/done/error/err_idx report status; rd_valid/rd_data return read samples; apb = bus master.
module apb_cmd_sequencer
    import apb_cmd_sequencer_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int TW       = 16,
    parameter int POLL_GAP = 2,
    localparam int IW      = $clog2(DEPTH),
    localparam int CW      = cmd_width(AW, DW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_we,
    input  logic [IW-1:0] cmd_waddr,
    input  logic [CW-1:0] cmd_wdata,
    input  logic          start,
    input  logic [TW-1:0] poll_limit,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_idx,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    apb_cmd_sequencer_if.master apb
);
    localparam int GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    state_e        state;
    logic [IW-1:0] pc;
    logic [CW-1:0] cur_cmd;
    logic [TW-1:0] poll_cnt;
    logic [TW-1:0] limit;
    logic [GW-1:0] gap_cnt;

    logic [AW-1:0] paddr_q;
    logic          pwrite_q;
    logic          psel_q;
    logic          penable_q;
    logic [DW-1:0] pwdata_q;

    logic [IW-1:0] ram_raddr;
    logic [CW-1:0] ram_rdata;

    op_e           cur_op;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_mask;
    logic [DW-1:0] cur_data;
    logic          poll_match;
    logic          limit_hit;

    // Writes are only accepted while idle so a running script cannot be modified.
    apb_cmd_sequencer_ram #(.DEPTH(DEPTH), .CW(CW), .IW(IW)) u_ram (
        .clk   (clk),
        .we    (cmd_we && (state == S_IDLE)),
        .waddr (cmd_waddr),
        .wdata (cmd_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The current command is latched into cur_cmd one step ahead of FETCH: slot 0 on start
    // (so a same-cycle slot write does not affect this run's first command), slot pc+1 in NEXT.
    assign ram_raddr = (state == S_NEXT) ? pc + IW'(1) : '0;

    assign cur_op   = op_e'(cur_cmd[CW-1 -: OP_W]);
    assign cur_addr = cur_cmd[2*DW +: AW];
    assign cur_mask = cur_cmd[DW +: DW];
    assign cur_data = cur_cmd[0 +: DW];

    assign poll_match = ((rd_data ^ cur_data) & cur_mask) == '0;
    // poll_limit of zero disables the timeout.
    assign limit_hit  = (limit != '0) && ((poll_cnt + TW'(1)) == limit);

    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWDATA  = pwdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            cur_cmd   <= '0;
            poll_cnt  <= '0;
            limit     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_idx   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            rd_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        pc      <= '0;
                        cur_cmd <= ram_rdata;
                        limit   <= poll_limit;
                    end
                end
                S_FETCH: begin
                    poll_cnt <= '0;
                    if (cur_op == OP_END) begin
                        state <= S_DONE;
                    end else begin
                        state    <= S_SETUP;
                        psel_q   <= 1'b1;
                        paddr_q  <= cur_addr;
                        pwrite_q <= (cur_op == OP_WRITE);
                        pwdata_q <= (cur_op == OP_WRITE) ? cur_data : '0;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb.PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        paddr_q   <= '0;
                        pwrite_q  <= 1'b0;
                        pwdata_q  <= '0;
                        if (cur_op != OP_WRITE) begin
                            rd_data  <= apb.PRDATA;
                            rd_valid <= 1'b1;
                        end
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cur_op != OP_POLL || poll_match) begin
                        state <= S_NEXT;
                    end else if (limit_hit) begin
                        state <= S_ERR;
                    end else begin
                        poll_cnt <= poll_cnt + TW'(1);
                        gap_cnt  <= '0;
                        if (POLL_GAP == 0) begin
                            // No spacing requested: re-issue the read immediately.
                            state   <= S_SETUP;
                            psel_q  <= 1'b1;
                            paddr_q <= cur_addr;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP_LAST)) begin
                        state   <= S_SETUP;
                        psel_q  <= 1'b1;
                        paddr_q <= cur_addr;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                S_NEXT: begin
                    // Running off the last slot acts as an implicit END.
                    if (pc == IW'(DEPTH - 1)) begin
                        state <= S_DONE;
                    end else begin
                        pc      <= pc + IW'(1);
                        cur_cmd <= ram_rdata;
                        state   <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    error   <= 1'b1;
                    err_idx <= pc;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
